// File: rtl/score_pkg.sv
// Shared types, constants and BCD helpers for the scoreboard.
package score_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_state_t;

    // Two-digit BCD increment that holds at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end
        if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Binary value of a two-digit BCD score.
    function automatic logic [6:0] bcd_value(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

endpackage

// File: rtl/BCD_Decoder.sv
// BCD digit to active-high 7-segment pattern, a..g in [6:0]; non-BCD is blank.
module BCD_Decoder
    import score_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Pure lookup; the caller registers the result.
    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'd0: segments = 7'b1111110;
            4'd1: segments = 7'b0110000;
            4'd2: segments = 7'b1101101;
            4'd3: segments = 7'b1111001;
            4'd4: segments = 7'b0110011;
            4'd5: segments = 7'b1011011;
            4'd6: segments = 7'b1011111;
            4'd7: segments = 7'b1110000;
            4'd8: segments = 7'b1111111;
            4'd9: segments = 7'b1111011;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_2d.sv
// Two-digit saturating BCD score counter with synchronous clear.
module bcd_counter_2d
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    input  logic       enable,
    output logic [7:0] bcd
);

    // Clear wins over increment; increments are gated by enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd <= 8'h00;
        end else if (clear) begin
            bcd <= 8'h00;
        end else if (inc && enable) begin
            bcd <= bcd_inc_sat(bcd);
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Pong score keeper with win detection and a 4-digit multiplexed display.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int unsigned CLKS_PER_DIGIT = 6250,
    parameter int unsigned BLINK_CLKS     = 12_500_000,
    parameter int unsigned WIN_SCORE      = 11
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_P1_Point,
    input  logic       i_P2_Point,
    input  logic       i_Clear,
    output logic [7:0] o_P1_Score,
    output logic [7:0] o_P2_Score,
    output logic       o_Game_Over,
    output logic [6:0] o_Segments,
    output logic [3:0] o_Digit_En
);

    localparam int unsigned SCAN_W  = $clog2(CLKS_PER_DIGIT);
    localparam int unsigned BLINK_W = $clog2(BLINK_CLKS + 1);
    localparam logic [6:0]  WIN_VAL = 7'(WIN_SCORE);

    digit_state_t       state, state_nxt;
    logic [SCAN_W-1:0]  scan_cnt, scan_cnt_nxt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic [7:0]         p1_score, p2_score, p1_nxt, p2_nxt;
    logic               game_over_nxt;
    logic               p1_win, p2_win;
    logic [3:0]         nibble, digit_en_nxt;
    logic               tens_digit, p1_digit;
    logic [6:0]         dec_seg, seg_nxt;

    bcd_counter_2d u_p1_cnt (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .clear  (i_Clear),
        .inc    (i_P1_Point),
        .enable (!o_Game_Over),
        .bcd    (p1_score)
    );

    bcd_counter_2d u_p2_cnt (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .clear  (i_Clear),
        .inc    (i_P2_Point),
        .enable (!o_Game_Over),
        .bcd    (p2_score)
    );

    BCD_Decoder u_dec (
        .digit    (nibble),
        .segments (dec_seg)
    );

    assign o_P1_Score = p1_score;
    assign o_P2_Score = p2_score;
    assign p1_win     = (bcd_value(p1_score) == WIN_VAL);
    assign p2_win     = (bcd_value(p2_score) == WIN_VAL);

    // Look ahead at the scores the counters will hold after this edge, so game-over lands on the same edge.
    always_comb begin
        p1_nxt = p1_score;
        p2_nxt = p2_score;
        if (i_Clear) begin
            p1_nxt = 8'h00;
            p2_nxt = 8'h00;
        end else if (!o_Game_Over) begin
            if (i_P1_Point) p1_nxt = bcd_inc_sat(p1_score);
            if (i_P2_Point) p2_nxt = bcd_inc_sat(p2_score);
        end
        game_over_nxt = !i_Clear && (o_Game_Over
                        || (bcd_value(p1_nxt) == WIN_VAL)
                        || (bcd_value(p2_nxt) == WIN_VAL));
    end

    // Game-over flag.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) o_Game_Over <= 1'b0;
        else       o_Game_Over <= game_over_nxt;
    end

    // Blink timer: runs only while the game is over, restarts lit on clear.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (i_Clear) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (o_Game_Over) begin
            if (blink_cnt == BLINK_W'(BLINK_CLKS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Scan FSM next state and the digit that will be shown after this edge.
    always_comb begin
        state_nxt    = state;
        scan_cnt_nxt = scan_cnt + SCAN_W'(1);
        digit_en_nxt = 4'b0001;
        nibble       = p1_score[7:4];
        tens_digit   = 1'b1;
        p1_digit     = 1'b1;
        if (scan_cnt == SCAN_W'(CLKS_PER_DIGIT - 1)) begin
            scan_cnt_nxt = '0;
            case (state)
                DIG0:    state_nxt = DIG1;
                DIG1:    state_nxt = DIG2;
                DIG2:    state_nxt = DIG3;
                default: state_nxt = DIG0;
            endcase
        end
        case (state_nxt)
            DIG0: begin
                digit_en_nxt = 4'b0001;
                nibble       = p1_score[7:4];
            end
            DIG1: begin
                digit_en_nxt = 4'b0010;
                nibble       = p1_score[3:0];
                tens_digit   = 1'b0;
            end
            DIG2: begin
                digit_en_nxt = 4'b0100;
                nibble       = p2_score[7:4];
                p1_digit     = 1'b0;
            end
            default: begin
                digit_en_nxt = 4'b1000;
                nibble       = p2_score[3:0];
                tens_digit   = 1'b0;
                p1_digit     = 1'b0;
            end
        endcase
    end

    // Leading-zero and winner-blink blanking on the decoded pattern.
    always_comb begin
        seg_nxt = dec_seg;
        if ((tens_digit && nibble == 4'd0)
            || (o_Game_Over && !blink_on && (p1_digit ? p1_win : p2_win))) begin
            seg_nxt = SEG_BLANK;
        end
    end

    // Scan state and display outputs update together so pattern and enable always match.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= DIG0;
            scan_cnt   <= '0;
            o_Digit_En <= 4'b0001;
            o_Segments <= SEG_BLANK;
        end else begin
            state      <= state_nxt;
            scan_cnt   <= scan_cnt_nxt;
            o_Digit_En <= digit_en_nxt;
            o_Segments <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with hand-computed expectations.
module tb_score_display_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p1 = 1'b0, p2 = 1'b0, clr = 1'b0;
    logic [7:0] p1_score, p2_score;
    logic       game_over;
    logic [6:0] seg;
    logic [3:0] en;

    logic       sat_p1 = 1'b0;
    logic [7:0] sat_s1, sat_s2;
    logic       sat_go;
    logic [6:0] sat_seg;
    logic [3:0] sat_en;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_3 = 7'b1111001;

    always #5 clk = ~clk;

    score_display_ctrl #(.CLKS_PER_DIGIT(4), .BLINK_CLKS(8), .WIN_SCORE(11)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_P1_Point(p1), .i_P2_Point(p2), .i_Clear(clr),
        .o_P1_Score(p1_score), .o_P2_Score(p2_score), .o_Game_Over(game_over),
        .o_Segments(seg), .o_Digit_En(en)
    );

    score_display_ctrl #(.CLKS_PER_DIGIT(4), .BLINK_CLKS(8), .WIN_SCORE(99)) dut_sat (
        .i_Clk(clk), .i_Rst(rst), .i_P1_Point(sat_p1), .i_P2_Point(1'b0), .i_Clear(1'b0),
        .o_P1_Score(sat_s1), .o_P2_Score(sat_s2), .o_Game_Over(sat_go),
        .o_Segments(sat_seg), .o_Digit_En(sat_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a, input logic b, input logic c);
        p1 = a; p2 = b; clr = c;
        tick();
        p1 = 1'b0; p2 = 1'b0; clr = 1'b0;
    endtask

    // Advance to the edge that newly selects the target digit, bounded.
    task automatic wait_digit(input string tag, input logic [3:0] target);
        logic [3:0] prev;
        logic       found;
        prev  = en;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (en == target && prev != target) found = 1'b1;
            prev = en;
        end
        check({tag, "_reached"}, 32'(found), 32'd1);
    endtask

    // Watch 40 cycles after the winning edge; winners blink 8 on / 8 off from the lit phase.
    task automatic blink_watch(input string tag, input logic p1_wins, input logic p2_wins,
                               input logic [6:0] p2_tens, input logic [6:0] p2_ones);
        logic       off;
        logic [6:0] exp;
        for (int k = 1; k <= 40; k++) begin
            tick();
            off = (((k - 1) / 8) % 2) == 1;
            case (en)
                4'b0001, 4'b0010: exp = (p1_wins && off) ? 7'b0 : SEG_1;
                4'b0100:          exp = (p2_wins && off) ? 7'b0 : p2_tens;
                default:          exp = (p2_wins && off) ? 7'b0 : p2_ones;
            endcase
            check($sformatf("%s_k%0d_en%b", tag, k, en), 32'(seg), 32'(exp));
        end
    endtask

    initial begin
        // Reset values while held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", 32'(en), 32'h1);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_p1", 32'(p1_score), 32'h00);
        check("rst_p2", 32'(p2_score), 32'h00);
        check("rst_go", 32'(game_over), 32'h0);
        check("rst_sat_en", 32'(sat_en), 32'h1);
        check("rst_sat_seg", 32'(sat_seg), 32'h0);
        rst = 1'b0;

        // Ten P1 points: carry into tens, then check each digit's pattern.
        repeat (10) pulse(1'b1, 1'b0, 1'b0);
        check("inc_p1", 32'(p1_score), 32'h10);
        check("inc_p2", 32'(p2_score), 32'h00);
        check("inc_go", 32'(game_over), 32'h0);
        wait_digit("dig0", 4'b0001);
        check("inc_dig0", 32'(seg), 32'(SEG_1));
        wait_digit("dig1", 4'b0010);
        check("inc_dig1", 32'(seg), 32'(SEG_0));
        wait_digit("dig2", 4'b0100);
        check("inc_dig2_blank", 32'(seg), 32'h0);
        wait_digit("dig3", 4'b1000);
        check("inc_dig3", 32'(seg), 32'(SEG_0));

        // Reset mid-frame takes effect immediately.
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("mrst_en", 32'(en), 32'h1);
        check("mrst_seg", 32'(seg), 32'h0);
        check("mrst_p1", 32'(p1_score), 32'h00);
        check("mrst_go", 32'(game_over), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Each digit held exactly 4 cycles in bit order.
        check("scan_0", 32'(en), 32'h1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("scan_%0d", i), 32'(en), 32'(4'b0001 << (i / 4)));
        end

        // Simultaneous points, then clear beating a point.
        pulse(1'b1, 1'b1, 1'b0);
        check("sim_p1", 32'(p1_score), 32'h01);
        check("sim_p2", 32'(p2_score), 32'h01);
        pulse(1'b1, 1'b0, 1'b1);
        check("clr_p1", 32'(p1_score), 32'h00);
        check("clr_p2", 32'(p2_score), 32'h00);

        // P1 wins 11-03.
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        repeat (10) pulse(1'b1, 1'b0, 1'b0);
        check("pre_win_go", 32'(game_over), 32'h0);
        pulse(1'b1, 1'b0, 1'b0);
        check("win_p1", 32'(p1_score), 32'h11);
        check("win_go", 32'(game_over), 32'h1);
        blink_watch("blink1", 1'b1, 1'b0, 7'b0, SEG_3);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("over_p1", 32'(p1_score), 32'h11);
        check("over_p2", 32'(p2_score), 32'h03);
        check("over_go", 32'(game_over), 32'h1);

        // Double win from 10-10.
        pulse(1'b0, 1'b0, 1'b1);
        check("clr_go", 32'(game_over), 32'h0);
        repeat (10) pulse(1'b1, 1'b1, 1'b0);
        check("dbl_pre_p1", 32'(p1_score), 32'h10);
        check("dbl_pre_p2", 32'(p2_score), 32'h10);
        pulse(1'b1, 1'b1, 1'b0);
        check("dbl_p1", 32'(p1_score), 32'h11);
        check("dbl_p2", 32'(p2_score), 32'h11);
        check("dbl_go", 32'(game_over), 32'h1);
        blink_watch("blink2", 1'b1, 1'b1, SEG_1, SEG_1);

        // Saturation at 99 with a winning score of 99.
        for (int i = 0; i < 105; i++) begin
            sat_p1 = 1'b1;
            tick();
        end
        sat_p1 = 1'b0;
        check("sat_p1", 32'(sat_s1), 32'h99);
        check("sat_p2", 32'(sat_s2), 32'h00);
        check("sat_go", 32'(sat_go), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Score keeper and display scanner for the Pong scoreboard. Holds two 2-digit BCD scores (P1, P2) updated by point pulses from the game logic and detects the winning score. Time-multiplexes one shared `BCD_Decoder` across four 7-segment digits, with leading-zero blanking and winner blinking. Sits between the game FSM and the board's segment/digit-enable pins.

## Interface
- `CLKS_PER_DIGIT`, 6250: clocks each digit stays selected; must be ≥ 2.
- `BLINK_CLKS`, 12_500_000: half-period of the winner blink, in clocks; must be ≥ 1.
- `WIN_SCORE`, 11: decimal winning score, 1..99.
- `i_Clk` in 1: system clock.
- `i_Rst` in 1: asynchronous, active-high reset.
- `i_P1_Point` in 1: one-cycle pulse, P1 scored.
- `i_P2_Point` in 1: one-cycle pulse, P2 scored.
- `i_Clear` in 1: synchronous new-game clear.
- `o_P1_Score` out 8: P1 score as BCD, tens in [7:4], ones in [3:0].
- `o_P2_Score` out 8: P2 score as BCD.
- `o_Game_Over` out 1: high while either score equals WIN_SCORE.
- `o_Segments` out 7: segments a..g in [6:0], active-high.
- `o_Digit_En` out 4: one-hot digit enable, active-high. Bit 0 = P1 tens, bit 1 = P1 ones, bit 2 = P2 tens, bit 3 = P2 ones.

## Operation
- **Reset values:**
  - Scores 8'h00.
  - `o_Game_Over` 0.
  - `o_Digit_En` 4'b0001.
  - `o_Segments` 7'b0000000.
  - Scan counter 0.
  - Blink counter 0, blink phase ON.
- **Scoring:**
  - A point pulse increments that player's BCD score.
  - Ones digit 9→0 with tens +1.
  - The score saturates at 8'h99.
  - Points are ignored while `o_Game_Over`=1.
- **Simultaneous points:** when both pulses arrive in the same cycle, both scores increment.
- **Clear priority:** `i_Clear` beats any point pulse in the same cycle. It sets both scores to 00, clears `o_Game_Over`, resets the blink counter and sets the blink phase to ON. It does not disturb the scan.
- **Game over:**
  - `o_Game_Over` is registered. It is set on the edge that makes either score equal WIN_SCORE (compare tens*10+ones).
  - It stays set until `i_Clear` or reset.
  - Winner = any player whose score equals WIN_SCORE; both players can win on a simultaneous point.
- **Scan FSM:**
  - States DIG0→DIG1→DIG2→DIG3→DIG0, advancing when the scan counter reaches CLKS_PER_DIGIT-1; the counter then wraps to 0.
  - `o_Digit_En` is one-hot for the current state.
- **Digit value:** the current state's nibble feeds the shared decoder.
- **Blanking:** `o_Segments` is forced to 7'b0000000 when either condition holds:
  - the digit is a tens digit and that player's tens nibble is 0 (score 05 shows " 5"); or
  - `o_Game_Over`=1, blink phase is OFF, and the digit belongs to a winner.
- **Blink:**
  - The counter runs only while `o_Game_Over`=1.
  - The phase toggles every BLINK_CLKS clocks, starting ON.
  - The loser's digits never blink.
- **Reset mid-scan:** asynchronous return to all reset values, taking effect immediately.

## Timing
- Point pulse sampled at edge N → `o_P*_Score` updated after edge N.
- `o_Game_Over` is updated at the same edge N as the score.
- `o_Segments` and `o_Digit_En` are both registered and change on the same edge. They never show one digit's pattern with another digit's enable.
- Score change → visible on `o_Segments` at the next register update for that digit: immediately if selected, else on reselection.
- Digit dwell is exactly CLKS_PER_DIGIT cycles; a full frame is 4*CLKS_PER_DIGIT cycles.

## Structure
- Shared package (`score_pkg`) holds:
  - `SEG_BLANK` = 7'b0000000;
  - digit-state encodings DIG0..DIG3;
  - the BCD-increment-with-saturate function.
- Sub-module `bcd_counter_2d`, instantiated twice. Its ports: clk, rst, clear, inc, enable, 8-bit BCD out.
- One `BCD_Decoder` instance, shared by all four digits.

## Test plan
All scenarios use CLKS_PER_DIGIT=4, BLINK_CLKS=8, WIN_SCORE=11.
- **Reset:** assert `i_Rst` mid-frame → `o_Digit_En`=4'b0001, `o_Segments`=0, scores 00 and `o_Game_Over`=0 immediately. After release, each digit is enabled for exactly 4 cycles, in bit order 0,1,2,3.
- **Increment:** 10 P1 pulses → `o_P1_Score`=8'h10. During DIG0 `o_Segments`=7'b0110000; during DIG1 7'b1111110. With P2=00, DIG2 is blanked and DIG3=7'b1111110.
- **Simultaneous and clear:**
  - P1 and P2 pulse in the same cycle → both scores +1.
  - `i_Clear` with `i_P1_Point` in the same cycle → both scores 00.
- **Win:**
  - P1 reaches 11 → `o_Game_Over`=1 on that edge.
  - Further P1/P2 pulses leave the scores at 11 and the loser's score unchanged.
  - P1 digits alternate lit/blank every 8 cycles, starting lit; P2 digits stay steady.
- **Double win:** P1=10, P2=10, both pulse together → both 11, `o_Game_Over`=1, both players' digits blink in phase.
- **Saturate:** with WIN_SCORE=99, 105 P1 pulses → `o_P1_Score` = 8'h99 and `o_Game_Over` = 1.
